// File: rtl/ro_stress_sched.sv
// Ring-oscillator stress sequencer: staggered bank enable, timed run, shutdown,
// and per-bank rising-edge activity counters with synchronized inputs.
module ro_stress_sched #(
  parameter int unsigned NBANK       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GAP_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SelW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NBANK-1:0] bank_mask,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [GAP_W-1:0] stage_gap,
  input  logic [NBANK-1:0] ro_data,
  output logic [NBANK-1:0] ro_en,
  output logic             busy,
  output logic             done,
  input  logic [SelW-1:0]  rd_sel,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [2:0] {StIdle, StRamp, StRun, StStop, StDone} state_e;

  localparam logic [CNT_W-1:0] StopLen = CNT_W'(SYNC_STAGES + 1);

  state_e                              state_q, state_d;
  logic [NBANK-1:0]                    en_q, en_d;
  logic [NBANK-1:0]                    rem_q, rem_d;
  logic [GAP_W-1:0]                    gap_q, gap_d;
  logic [GAP_W-1:0]                    gcnt_q, gcnt_d;
  logic [CNT_W-1:0]                    run_q, run_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][NBANK-1:0]   sync_q, sync_d;
  logic [NBANK-1:0]                    hist_q, hist_d;
  logic [NBANK-1:0][CNT_W-1:0]         ecnt_q, ecnt_d;

  logic             accept;
  logic             counting;
  logic [NBANK-1:0] rise;
  logic [GAP_W-1:0] gap_eff;

  function automatic logic [NBANK-1:0] lowest(input logic [NBANK-1:0] x);
    return x & (~x + NBANK'(1));
  endfunction

  assign accept   = (state_q == StIdle) && start;
  assign counting = (state_q == StRamp) || (state_q == StRun) || (state_q == StStop);
  assign gap_eff  = (stage_gap == '0) ? GAP_W'(1) : stage_gap;
  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRamp;
          en_d    = lowest(bank_mask);
          rem_d   = bank_mask & ~lowest(bank_mask);
          gap_d   = gap_eff;
          gcnt_d  = gap_eff;
          run_d   = run_cycles;
        end
      end
      StRamp: begin
        if (abort || (rem_q == '0 && run_q == '0)) begin
          state_d = StStop;
          en_d    = '0;
          rem_d   = '0;
          cnt_d   = StopLen;
        end else if (rem_q == '0) begin
          state_d = StRun;
          cnt_d   = run_q;
        end else if (gcnt_q == GAP_W'(1)) begin
          en_d   = en_q | lowest(rem_q);
          rem_d  = rem_q & ~lowest(rem_q);
          gcnt_d = gap_q;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      StRun: begin
        if (abort || cnt_q == CNT_W'(1)) begin
          state_d = StStop;
          en_d    = '0;
          cnt_d   = StopLen;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StStop: begin
        // Stay long enough for edges still in the synchronizer to land.
        if (cnt_q == CNT_W'(1)) state_d = StDone;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ro_data};
    hist_d = sync_q[SYNC_STAGES-1];
    ecnt_d = ecnt_q;
    for (int i = 0; i < NBANK; i++) begin
      if (accept) begin
        ecnt_d[i] = '0;
      end else if (counting && rise[i] && ecnt_q[i] != '1) begin
        ecnt_d[i] = ecnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      en_q    <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      run_q   <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      hist_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (rd_sel == SelW'(i)) rd_cnt = ecnt_q[i];
    end
  end

  assign ro_en = en_q;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_ro_stress_sched.sv
// Directed bench for ro_stress_sched: default instance plus a narrow-counter,
// three-bank instance for saturation and out-of-range readout.
module tb_ro_stress_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [3:0]  bank_mask = '0;
  logic [15:0] run_cycles = '0;
  logic [7:0]  stage_gap = '0;
  logic [3:0]  ro_data = '0;
  logic [3:0]  ro_en;
  logic        busy, done;
  logic [1:0]  rd_sel = '0;
  logic [15:0] rd_cnt;

  logic        s_start = 1'b0, s_abort = 1'b0;
  logic [2:0]  s_mask = '0;
  logic [3:0]  s_run = '0;
  logic [7:0]  s_gap = '0;
  logic [2:0]  s_ro_data = '0;
  logic [2:0]  s_ro_en;
  logic        s_busy, s_done;
  logic [1:0]  s_rd_sel = '0;
  logic [3:0]  s_rd_cnt;

  int total = 0;
  int bad = 0;
  int tcnt = 0;
  logic [3:0] tog_mask = '0;
  int tog_half = 4;
  logic s_tog = 1'b0;

  logic [3:0] r_en   [0:31];
  logic       r_busy [0:31];
  logic       r_done [0:31];

  ro_stress_sched u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bank_mask(bank_mask),
    .run_cycles(run_cycles), .stage_gap(stage_gap), .ro_data(ro_data), .ro_en(ro_en),
    .busy(busy), .done(done), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  ro_stress_sched #(.NBANK(3), .CNT_W(4), .GAP_W(8), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .bank_mask(s_mask),
    .run_cycles(s_run), .stage_gap(s_gap), .ro_data(s_ro_data), .ro_en(s_ro_en),
    .busy(s_busy), .done(s_done), .rd_sel(s_rd_sel), .rd_cnt(s_rd_cnt)
  );

  always #5 clk = ~clk;

  // Oscillator stand-ins, changing on the falling edge.
  always @(negedge clk) begin
    tcnt <= tcnt + 1;
    if (tcnt % tog_half == 0) ro_data <= ro_data ^ tog_mask;
    if (s_tog && (tcnt % 2 == 0)) s_ro_data <= ~s_ro_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] m, input logic [7:0] g, input logic [15:0] r);
    bank_mask  = m;
    stage_gap  = g;
    run_cycles = r;
    start      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    total++;
    if (ro_en !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b want 0000/0/0", ro_en, busy, done);
    end
    total++;
    if (rd_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", rd_cnt);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_degenerate();
    int nbusy;
    logic [3:0] en_or;
    nbusy = 0;
    en_or = '0;
    launch(4'b0000, 8'd0, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) start = 1'b0;
      r_done[k] = done;
      if (busy) nbusy++;
      en_or |= ro_en;
    end
    total++;
    if (nbusy != 5) begin
      bad++;
      $display("FAIL degen_busy_len: got %0d want 5", nbusy);
    end
    total++;
    if (r_done[5] !== 1'b1 || r_done[4] !== 1'b0) begin
      bad++;
      $display("FAIL degen_done: got done4=%b done5=%b want 0/1", r_done[4], r_done[5]);
    end
    total++;
    if (en_or !== 4'b0) begin
      bad++;
      $display("FAIL degen_en: got %b want 0000", en_or);
    end
  endtask

  task automatic test_stagger();
    launch(4'b1011, 8'd3, 16'd10);
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1) start = 1'b0;
      r_en[k] = ro_en;
      r_busy[k] = busy;
      r_done[k] = done;
    end
    total++;
    if (r_en[1] !== 4'b0001 || r_en[3] !== 4'b0001) begin
      bad++;
      $display("FAIL stag_bit0: got t1=%b t3=%b want 0001/0001", r_en[1], r_en[3]);
    end
    total++;
    if (r_en[4] !== 4'b0011 || r_en[6] !== 4'b0011) begin
      bad++;
      $display("FAIL stag_bit1: got t4=%b t6=%b want 0011/0011", r_en[4], r_en[6]);
    end
    total++;
    if (r_en[7] !== 4'b1011 || r_en[17] !== 4'b1011) begin
      bad++;
      $display("FAIL stag_bit3: got t7=%b t17=%b want 1011/1011", r_en[7], r_en[17]);
    end
    total++;
    if (r_en[18] !== 4'b0000) begin
      bad++;
      $display("FAIL stag_off: got t18=%b want 0000", r_en[18]);
    end
    total++;
    if (r_done[20] !== 1'b0 || r_done[21] !== 1'b1 || r_done[22] !== 1'b0) begin
      bad++;
      $display("FAIL stag_done: got t20..22=%b%b%b want 010", r_done[20], r_done[21], r_done[22]);
    end
    total++;
    if (r_busy[1] !== 1'b1 || r_busy[21] !== 1'b1 || r_busy[22] !== 1'b0) begin
      bad++;
      $display("FAIL stag_busy: got t1=%b t21=%b t22=%b want 1/1/0",
               r_busy[1], r_busy[21], r_busy[22]);
    end
    rd_sel = 2'd3;
    #1;
    total++;
    if (rd_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stag_quiet_cnt: got %0d want 0", rd_cnt);
    end
  endtask

  task automatic test_abort();
    logic [3:0] en_or;
    en_or = '0;
    launch(4'b1111, 8'd5, 16'd10);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (k == 2) launch(4'b0010, 8'd1, 16'd0);
      if (k == 3) begin
        start = 1'b0;
        abort = 1'b1;
      end
      if (k == 4) abort = 1'b0;
      r_en[k] = ro_en;
      r_busy[k] = busy;
      r_done[k] = done;
      en_or |= ro_en;
    end
    total++;
    if (en_or !== 4'b0001) begin
      bad++;
      $display("FAIL abort_en_seen: got %b want 0001", en_or);
    end
    total++;
    if (r_en[3] !== 4'b0001 || r_en[4] !== 4'b0000) begin
      bad++;
      $display("FAIL abort_drop: got t3=%b t4=%b want 0001/0000", r_en[3], r_en[4]);
    end
    total++;
    if (r_done[6] !== 1'b0 || r_done[7] !== 1'b1 || r_busy[8] !== 1'b0) begin
      bad++;
      $display("FAIL abort_done: got d6=%b d7=%b b8=%b want 0/1/0",
               r_done[6], r_done[7], r_busy[8]);
    end
  endtask

  task automatic test_ignored_start();
    logic [3:0] en_or;
    en_or = '0;
    launch(4'b0001, 8'd1, 16'd5);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (k == 3) launch(4'b1111, 8'd0, 16'd0);
      if (k == 4) start = 1'b0;
      abort = (k == 8);
      r_en[k] = ro_en;
      r_done[k] = done;
      en_or |= ro_en;
    end
    abort = 1'b0;
    total++;
    if (en_or !== 4'b0001 || r_en[6] !== 4'b0001 || r_en[7] !== 4'b0000) begin
      bad++;
      $display("FAIL ign_en: got or=%b t6=%b t7=%b want 0001/0001/0000", en_or, r_en[6], r_en[7]);
    end
    total++;
    if (r_done[9] !== 1'b0 || r_done[10] !== 1'b1) begin
      bad++;
      $display("FAIL ign_done: got d9=%b d10=%b want 0/1", r_done[9], r_done[10]);
    end
  endtask

  task automatic test_edge_count();
    int waited;
    tog_mask = 4'b0100;
    tog_half = 4;
    launch(4'b0100, 8'd1, 16'd64);
    step();
    start = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    tog_mask = 4'b0000;
    total++;
    if (waited >= 200) begin
      bad++;
      $display("FAIL edge_done_timeout: got no done in %0d cycles want done", waited);
    end
    rd_sel = 2'd2;
    #1;
    total++;
    if (rd_cnt < 16'd7 || rd_cnt > 16'd9) begin
      bad++;
      $display("FAIL edge_cnt2: got %0d want 7..9", rd_cnt);
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 2) continue;
      rd_sel = 2'(b);
      #1;
      total++;
      if (rd_cnt !== 16'd0) begin
        bad++;
        $display("FAIL edge_cnt_other%0d: got %0d want 0", b, rd_cnt);
      end
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int ndone;
    tog_mask = 4'b1111;
    tog_half = 2;
    launch(4'b1111, 8'd1, 16'd20);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) start = 1'b0;
    end
    rd_sel = 2'd0;
    #1;
    total++;
    if (busy !== 1'b1 || rd_cnt == 16'd0) begin
      bad++;
      $display("FAIL rstmid_pre: got busy=%b cnt=%0d want 1/nonzero", busy, rd_cnt);
    end
    rst = 1'b0;
    step();
    total++;
    if (ro_en !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_out: got en=%b busy=%b done=%b want 0000/0/0", ro_en, busy, done);
    end
    for (int b = 0; b < 4; b++) begin
      rd_sel = 2'(b);
      #1;
      total++;
      if (rd_cnt !== 16'd0) begin
        bad++;
        $display("FAIL rstmid_cnt%0d: got %0d want 0", b, rd_cnt);
      end
    end
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    tog_mask = 4'b0000;
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL rstmid_idle: got %0d active cycles want 0", ndone);
    end
  endtask

  task automatic test_saturation();
    int waited;
    s_tog   = 1'b1;
    s_mask  = 3'b101;
    s_gap   = 8'd60;
    s_run   = 4'd15;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    waited = 0;
    while (s_done !== 1'b1 && waited < 150) begin
      step();
      waited++;
    end
    total++;
    if (waited >= 150) begin
      bad++;
      $display("FAIL sat_done_timeout: got no done in %0d cycles want done", waited);
    end
    for (int k = 0; k < 10; k++) step();
    for (int b = 0; b < 3; b++) begin
      s_rd_sel = 2'(b);
      #1;
      total++;
      if (s_rd_cnt !== 4'hF) begin
        bad++;
        $display("FAIL sat_cnt%0d: got %h want f", b, s_rd_cnt);
      end
    end
    s_rd_sel = 2'd3;
    #1;
    total++;
    if (s_rd_cnt !== 4'h0) begin
      bad++;
      $display("FAIL sat_sel_oob: got %h want 0", s_rd_cnt);
    end
    s_tog = 1'b0;
  endtask

  initial begin
    test_reset();
    test_degenerate();
    test_stagger();
    test_abort();
    test_ignored_start();
    test_edge_count();
    test_reset_midrun();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
